// File: rtl/xm_mem_pkg.sv
// Shared definitions for the memory-interface stage.
//   state_t        : transaction FSM states (IDLE, REQ, RESP)
//   BE_WORD/LO/HI  : byte-enable patterns, bit [1] is the high lane
//   RD_ABORT_FILL  : bit replicated across rdData when a read times out
package xm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  localparam logic RD_ABORT_FILL = 1'b1;

endpackage

// File: rtl/xm_mem_if_if.sv
// External memory bus bundle.
//   busReq   : request, held for the whole wait phase
//   busWe    : write enable
//   busAdr   : word-aligned address
//   busBe    : byte enables, [1] = high lane
//   busWData : write data
//   busAck   : acknowledge, read data valid in the same cycle
//   busRData : read data
// master = the CPU-side stage, slave = the memory.
interface xm_mem_if_if #(
  parameter int WORD = 16
);

  logic            busReq;
  logic            busWe;
  logic [WORD-1:0] busAdr;
  logic [1:0]      busBe;
  logic [WORD-1:0] busWData;
  logic            busAck;
  logic [WORD-1:0] busRData;

  modport master (
    output busReq, busWe, busAdr, busBe, busWData,
    input  busAck, busRData
  );

  modport slave (
    input  busReq, busWe, busAdr, busBe, busWData,
    output busAck, busRData
  );

endinterface

// File: rtl/xm_mem_lane.sv
// Combinational byte-lane steering.
//   byteOp : 1 = byte access, 0 = word access
//   adrLsb : byte address bit 0, selects the lane for byte accesses
//   wrData : captured write data
//   rData  : raw bus read data
//   be     : bus byte enables
//   wData  : bus write data (low byte replicated on both lanes for byte writes)
//   rdSel  : read data as seen by the CPU (selected byte zero-extended)
module xm_mem_lane
  import xm_mem_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            byteOp,
  input  logic            adrLsb,
  input  logic [WORD-1:0] wrData,
  input  logic [WORD-1:0] rData,
  output logic [1:0]      be,
  output logic [WORD-1:0] wData,
  output logic [WORD-1:0] rdSel
);

  always_comb begin
    be    = BE_WORD;
    wData = wrData;
    rdSel = rData;
    if (byteOp) begin
      be    = adrLsb ? BE_HI : BE_LO;
      // Replicating the byte lets the memory pick it up on whichever lane is enabled.
      wData = WORD'({wrData[7:0], wrData[7:0]});
      rdSel = adrLsb ? WORD'(rData[15:8]) : WORD'(rData[7:0]);
    end
  end

endmodule

// File: rtl/xm_mem_if.sv
// Memory-interface stage between the CPU datapath and the external bus.
// Takes one word/byte request, runs a req/ack bus transaction with a wait
// timeout, and returns a one-cycle read-data strobe to the control plane.
//   clk_i, arst_i (async, active-low)
//   memEn_i, memRW_i (1=read), byteOp_i, adr_i, wrData_i : CPU request
//   memBusy_o : transaction outstanding (includes the request cycle)
//   memWr_o   : one-cycle read-data-valid strobe
//   rdData_o  : registered read data, held until the next read completion
//   memErr_o  : one-cycle timeout pulse, coincident with memWr_o on reads
//   bus       : external memory bus (master side)
module xm_mem_if
  import xm_mem_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] adr_i,
  input  logic [WORD-1:0] wrData_i,
  output logic            memBusy_o,
  output logic            memWr_o,
  output logic [WORD-1:0] rdData_o,
  output logic            memErr_o,
  xm_mem_if_if.master     bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);

  state_t          state, stateNxt;
  logic            rdOp, byteOp, aborted;
  logic [WORD-1:0] adrReg, wdReg, rdReg;
  logic [CW-1:0]   waitCnt;
  logic            waitDone;

  logic [1:0]      laneBe;
  logic [WORD-1:0] laneWData, laneRData;

  logic            reqC, weC, memWrC, memErrC;
  logic [WORD-1:0] adrC, wDataC;
  logic [1:0]      beC;

  assign waitDone = (waitCnt == CNT_LAST);

  xm_mem_lane #(.WORD(WORD)) uLane (
    .byteOp (byteOp),
    .adrLsb (adrReg[0]),
    .wrData (wdReg),
    .rData  (bus.busRData),
    .be     (laneBe),
    .wData  (laneWData),
    .rdSel  (laneRData)
  );

  // State register
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) state <= IDLE;
    else         state <= stateNxt;
  end

  // Next-state logic; an ack in the last wait cycle beats the timeout
  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (memEn_i) stateNxt = REQ;
      REQ:     if (bus.busAck || waitDone) stateNxt = RESP;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Request capture, wait counter and read-data register
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      rdOp    <= 1'b0;
      byteOp  <= 1'b0;
      aborted <= 1'b0;
      adrReg  <= '0;
      wdReg   <= '0;
      rdReg   <= '0;
      waitCnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memEn_i) begin
            rdOp    <= memRW_i;
            byteOp  <= byteOp_i;
            adrReg  <= adr_i;
            wdReg   <= wrData_i;
            waitCnt <= '0;
            aborted <= 1'b0;
          end
        end
        REQ: begin
          if (bus.busAck) begin
            if (rdOp) rdReg <= laneRData;
          end else if (waitDone) begin
            aborted <= 1'b1;
            if (rdOp) rdReg <= {WORD{RD_ABORT_FILL}};
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; bus lines are zero outside REQ
  always_comb begin
    reqC    = 1'b0;
    weC     = 1'b0;
    adrC    = '0;
    beC     = '0;
    wDataC  = '0;
    memWrC  = 1'b0;
    memErrC = 1'b0;
    unique case (state)
      REQ: begin
        reqC   = 1'b1;
        weC    = ~rdOp;
        adrC   = {adrReg[WORD-1:1], 1'b0};
        beC    = laneBe;
        wDataC = laneWData;
      end
      RESP: begin
        memWrC  = rdOp;
        memErrC = aborted;
      end
      default: ;
    endcase
  end

  assign bus.busReq   = reqC;
  assign bus.busWe    = weC;
  assign bus.busAdr   = adrC;
  assign bus.busBe    = beC;
  assign bus.busWData = wDataC;

  assign memWr_o   = memWrC;
  assign memErr_o  = memErrC;
  assign rdData_o  = rdReg;
  // Busy already in the accept cycle so the datapath stalls immediately.
  assign memBusy_o = (state != IDLE) | memEn_i;

endmodule

// File: tb/tb_xm_mem_if.sv
module tb_xm_mem_if;

  localparam int WORD    = 16;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        memEn = 1'b0, memRW = 1'b0, byteOp = 1'b0;
  logic [15:0] adr = '0, wrData = '0;
  logic        memBusy, memWr, memErr;
  logic [15:0] rdData;

  xm_mem_if_if #(.WORD(WORD)) bus();

  xm_mem_if #(.WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
    .clk_i     (clk),
    .arst_i    (arst),
    .memEn_i   (memEn),
    .memRW_i   (memRW),
    .byteOp_i  (byteOp),
    .adr_i     (adr),
    .wrData_i  (wrData),
    .memBusy_o (memBusy),
    .memWr_o   (memWr),
    .rdData_o  (rdData),
    .memErr_o  (memErr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction accepted in cycle a requests the bus from a+1 until it is
  // acked or has waited TIMEOUT+1 cycles (last request cycle e); the cycle
  // after e is the completion cycle.
  int          n = 0;
  int          accCyc = -1;
  int          lastReq = -1;
  logic        tRd = 1'b0, tByte = 1'b0, tAbort = 1'b0;
  logic [15:0] tAdr = '0, tWd = '0, mRd = '0;
  logic        eReq, eResp;

  function automatic logic [15:0] steerRd(input logic byteAcc, input logic [15:0] a,
                                          input logic [15:0] r);
    if (!byteAcc) return r;
    return a[0] ? {8'h00, r[15:8]} : {8'h00, r[7:0]};
  endfunction

  always @(negedge clk) begin
    if (!arst) begin
      accCyc  = -1;
      lastReq = -1;
      mRd     = '0;
      chk("m_rst_busReq", bus.busReq, 0);
      chk("m_rst_busWe", bus.busWe, 0);
      chk("m_rst_busAdr", bus.busAdr, 0);
      chk("m_rst_busBe", bus.busBe, 0);
      chk("m_rst_busWData", bus.busWData, 0);
      chk("m_rst_memWr", memWr, 0);
      chk("m_rst_memErr", memErr, 0);
      chk("m_rst_rdData", rdData, 0);
      chk("m_rst_memBusy", memBusy, memEn);
    end else begin
      eReq  = (accCyc >= 0) && (n > accCyc) && (lastReq < 0);
      eResp = (lastReq >= 0) && (n == lastReq + 1);
      chk("m_busReq", bus.busReq, eReq);
      chk("m_busWe", bus.busWe, eReq && !tRd);
      chk("m_busAdr", bus.busAdr, eReq ? (tAdr & 16'hFFFE) : 16'h0);
      chk("m_busBe", bus.busBe, eReq ? (tByte ? (tAdr[0] ? 2'b10 : 2'b01) : 2'b11) : 2'b00);
      chk("m_busWData", bus.busWData, eReq ? (tByte ? {tWd[7:0], tWd[7:0]} : tWd) : 16'h0);
      chk("m_memBusy", memBusy, (accCyc >= 0) || memEn);
      chk("m_memWr", memWr, eResp && tRd);
      chk("m_memErr", memErr, eResp && tAbort);
      chk("m_rdData", rdData, mRd);
      if (eReq) begin
        if (bus.busAck) begin
          lastReq = n;
          if (tRd) mRd = steerRd(tByte, tAdr, bus.busRData);
        end else if (n - accCyc - 1 == TIMEOUT) begin
          lastReq = n;
          tAbort  = 1'b1;
          if (tRd) mRd = 16'hFFFF;
        end
      end else if (eResp) begin
        accCyc  = -1;
        lastReq = -1;
      end else if (accCyc < 0 && memEn) begin
        accCyc = n;
        tRd    = memRW;
        tByte  = byteOp;
        tAdr   = adr;
        tWd    = wrData;
        tAbort = 1'b0;
      end
    end
    n++;
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   reqCnt;
  int   pulses;
  logic seen;

  initial begin
    bus.busAck   = 1'b0;
    bus.busRData = '0;
    arst         = 1'b0;
    @(posedge clk);
    #4;
    chk("rst_busReq", bus.busReq, 0);
    chk("rst_rdData", rdData, 0);
    chk("rst_memBusy", memBusy, 0);
    @(posedge clk);
    #1;
    arst = 1'b1;
    tick();

    // word read, odd address aligned down, ack in cycle 2
    memEn = 1; memRW = 1; byteOp = 0; adr = 16'h1001; wrData = 16'h0;
    tick(); memEn = 0; #3;
    chk("wr_rd_busReq", bus.busReq, 1);
    chk("wr_rd_busAdr", bus.busAdr, 16'h1000);
    chk("wr_rd_busBe", bus.busBe, 2'b11);
    chk("wr_rd_busWe", bus.busWe, 0);
    tick(); bus.busAck = 1; bus.busRData = 16'hBEEF;
    tick(); bus.busAck = 0; #3;
    chk("wd_rd_memWr", memWr, 1);
    chk("wd_rd_rdData", rdData, 16'hBEEF);
    chk("wd_rd_memErr", memErr, 0);
    tick(); #3;
    chk("wd_rd_idleBusy", memBusy, 0);

    // byte write, high lane
    memEn = 1; memRW = 0; byteOp = 1; adr = 16'h2003; wrData = 16'h12A5;
    tick(); memEn = 0; bus.busAck = 1; #3;
    chk("bw_busWe", bus.busWe, 1);
    chk("bw_busBe", bus.busBe, 2'b10);
    chk("bw_busWData", bus.busWData, 16'hA5A5);
    chk("bw_busAdr", bus.busAdr, 16'h2002);
    tick(); bus.busAck = 0; #3;
    chk("bw_noMemWr", memWr, 0);
    chk("bw_rdHeld", rdData, 16'hBEEF);
    tick();

    // byte read, high lane
    memEn = 1; memRW = 1; byteOp = 1; adr = 16'h3001;
    tick(); memEn = 0; bus.busAck = 1; bus.busRData = 16'h7C3E;
    tick(); bus.busAck = 0; #3;
    chk("br_hi_memWr", memWr, 1);
    chk("br_hi_rdData", rdData, 16'h007C);
    tick();

    // byte read, low lane
    memEn = 1; memRW = 1; byteOp = 1; adr = 16'h3000;
    tick(); memEn = 0; bus.busAck = 1; bus.busRData = 16'h7C3E; #3;
    chk("br_lo_busBe", bus.busBe, 2'b01);
    tick(); bus.busAck = 0; #3;
    chk("br_lo_rdData", rdData, 16'h003E);
    tick();

    // read with no ack: timeout
    memEn = 1; memRW = 1; byteOp = 0; adr = 16'h4000;
    reqCnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(); memEn = 0; #3;
      if (bus.busReq) reqCnt++;
      if (memWr) begin
        seen = 1;
        chk("to_memErr", memErr, 1);
        chk("to_rdData", rdData, 16'hFFFF);
      end
    end
    chk("to_completed", seen, 1);
    chk("to_reqCycles", reqCnt, TIMEOUT + 1);
    tick();

    // ack in the last wait cycle wins over the timeout
    memEn = 1; memRW = 1; byteOp = 0; adr = 16'h4100; bus.busRData = 16'h5A5A;
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      tick(); memEn = 0; bus.busAck = (i == TIMEOUT + 1);
    end
    tick(); bus.busAck = 0; #3;
    chk("late_memWr", memWr, 1);
    chk("late_memErr", memErr, 0);
    chk("late_rdData", rdData, 16'h5A5A);
    tick();

    // write with no ack: error only, read data untouched
    memEn = 1; memRW = 0; byteOp = 0; adr = 16'h4200; wrData = 16'hCAFE;
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      tick(); memEn = 0;
    end
    tick(); #3;
    chk("wto_memErr", memErr, 1);
    chk("wto_memWr", memWr, 0);
    chk("wto_rdData", rdData, 16'h5A5A);
    tick();

    // back-to-back with memEn held and ack always high
    memEn = 1; memRW = 1; byteOp = 0; adr = 16'h5002;
    bus.busAck = 1; bus.busRData = 16'h1234; pulses = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      #3;
      chk("b2b_busy", memBusy, 1);
      if (memWr) pulses++;
    end
    tick(); memEn = 0; bus.busAck = 0; #3;
    chk("b2b_pulses", pulses, 3);
    chk("b2b_idle", memBusy, 0);
    chk("b2b_rdData", rdData, 16'h1234);
    tick();

    // asynchronous reset in the middle of a request
    memEn = 1; memRW = 1; byteOp = 0; adr = 16'h6000;
    tick(); memEn = 0;
    tick(); #1;
    chk("arst_reqBefore", bus.busReq, 1);
    #1; arst = 0; #1;
    chk("arst_reqDropped", bus.busReq, 0);
    chk("arst_rdCleared", rdData, 0);
    tick();
    tick(); arst = 1;
    tick(); #3;
    chk("post_busReq", bus.busReq, 0);
    chk("post_busWe", bus.busWe, 0);
    chk("post_busAdr", bus.busAdr, 0);
    chk("post_busBe", bus.busBe, 0);
    chk("post_busWData", bus.busWData, 0);
    chk("post_memWr", memWr, 0);
    chk("post_memErr", memErr, 0);
    chk("post_rdData", rdData, 0);
    chk("post_memBusy", memBusy, 0);

    // normal transaction after reset
    memEn = 1; memRW = 1; byteOp = 0; adr = 16'h7000;
    tick(); memEn = 0; bus.busAck = 1; bus.busRData = 16'h0F0F;
    tick(); bus.busAck = 0; #3;
    chk("post_txn_memWr", memWr, 1);
    chk("post_txn_rdData", rdData, 16'h0F0F);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
